// File: rtl/lock_pkg.sv
// Shared types and helpers for the combination-lock sequencing controller.
package lock_pkg;

    localparam int CODE_W_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_UNSET   = 3'd0,
        ST_LOCKED  = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    // Wide enough to hold max(open, lockout) - 1, never narrower than one bit.
    function automatic int timer_width(input int open_cycles, input int lockout_cycles);
        int longest;
        longest = (open_cycles > lockout_cycles) ? open_cycles : lockout_cycles;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that saturates at zero; shared by the OPEN and LOCKOUT windows.
module lock_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lock_seq_ctrl.sv
// Sequencing controller for the combination lock: enrol, attempt/compare,
// timed unlock window and retry limit with timed lockout.
module lock_seq_ctrl
    import lock_pkg::*;
#(
    parameter int CODE_W         = CODE_W_DEFAULT,
    parameter int MAX_TRIES      = 3,
    parameter int OPEN_CYCLES    = 8,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [CODE_W-1:0]              code_in,
    input  logic                           code_valid,
    input  logic                           enroll,
    input  logic                           relock,
    output logic                           code_ready,
    output logic                           unlock,
    output logic                           alarm,
    output logic                           match_pulse,
    output logic                           fail_pulse,
    output logic [$clog2(MAX_TRIES+1)-1:0] tries_left,
    output logic [2:0]                     state_o
);

    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int TIMER_W = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);

    state_t               state, next_state;
    logic [CODE_W-1:0]    stored, candidate;
    logic [TRIES_W-1:0]   next_tries;
    logic                 store_en, cand_en, match_d, fail_d;
    logic                 timer_load, timer_en, timer_zero;
    logic [TIMER_W-1:0]   timer_val;
    logic                 xfer;

    lock_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    assign code_ready = (state == ST_UNSET) || (state == ST_LOCKED) || (state == ST_OPEN);
    assign xfer       = code_valid && code_ready;
    assign timer_en   = (state == ST_OPEN) || (state == ST_LOCKOUT);
    assign state_o    = state;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state = state;
        next_tries = tries_left;
        store_en   = 1'b0;
        cand_en    = 1'b0;
        match_d    = 1'b0;
        fail_d     = 1'b0;
        timer_load = 1'b0;
        timer_val  = '0;

        unique case (state)
            ST_UNSET: begin
                if (xfer && enroll) begin
                    store_en   = 1'b1;
                    next_state = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (xfer && enroll) begin
                    fail_d = 1'b1;
                end else if (xfer) begin
                    cand_en    = 1'b1;
                    next_state = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (candidate == stored) begin
                    next_state = ST_OPEN;
                    match_d    = 1'b1;
                    next_tries = TRIES_W'(MAX_TRIES);
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(OPEN_CYCLES - 1);
                end else if (tries_left > TRIES_W'(1)) begin
                    next_tries = tries_left - 1'b1;
                    fail_d     = 1'b1;
                    next_state = ST_LOCKED;
                end else begin
                    next_tries = '0;
                    fail_d     = 1'b1;
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(LOCKOUT_CYCLES - 1);
                    next_state = ST_LOCKOUT;
                end
            end
            ST_OPEN: begin
                // Early exits clear the timer so it rests at zero while LOCKED.
                if (xfer && enroll) begin
                    store_en   = 1'b1;
                    timer_load = 1'b1;
                    next_state = ST_LOCKED;
                end else if (relock) begin
                    timer_load = 1'b1;
                    next_state = ST_LOCKED;
                end else if (timer_zero) begin
                    next_state = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (timer_zero) begin
                    next_tries = TRIES_W'(MAX_TRIES);
                    next_state = ST_LOCKED;
                end
            end
            default: next_state = ST_UNSET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the stored code is reset too, so a reset always forces re-enrolment.
            state       <= ST_UNSET;
            stored      <= '0;
            candidate   <= '0;
            tries_left  <= TRIES_W'(MAX_TRIES);
            unlock      <= 1'b0;
            alarm       <= 1'b0;
            match_pulse <= 1'b0;
            fail_pulse  <= 1'b0;
        end else begin
            state       <= next_state;
            if (store_en) stored    <= code_in;
            if (cand_en)  candidate <= code_in;
            tries_left  <= next_tries;
            unlock      <= (next_state == ST_OPEN);
            alarm       <= (next_state == ST_LOCKOUT);
            match_pulse <= match_d;
            fail_pulse  <= fail_d;
        end
    end

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed self-checking bench for lock_seq_ctrl with default parameters.
module tb_lock_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] code_in = '0;
    logic        code_valid = 1'b0;
    logic        enroll = 1'b0;
    logic        relock = 1'b0;
    logic        code_ready, unlock, alarm, match_pulse, fail_pulse;
    logic [1:0]  tries_left;
    logic [2:0]  state_o;

    int passed = 0;
    int total  = 0;

    lock_seq_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .code_in     (code_in),
        .code_valid  (code_valid),
        .enroll      (enroll),
        .relock      (relock),
        .code_ready  (code_ready),
        .unlock      (unlock),
        .alarm       (alarm),
        .match_pulse (match_pulse),
        .fail_pulse  (fail_pulse),
        .tries_left  (tries_left),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Every drive and sample happens 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        code_valid = 1'b0; enroll = 1'b0; relock = 1'b0; code_in = '0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic enroll_code(input logic [15:0] c);
        code_in = c; code_valid = 1'b1; enroll = 1'b1;
        tick();
        code_valid = 1'b0; enroll = 1'b0;
    endtask

    // Leaves the bench sampling in the cycle after the result edge E1.
    task automatic attempt(input logic [15:0] c);
        code_in = c; code_valid = 1'b1; enroll = 1'b0;
        tick();
        code_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        total++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_o); else passed++;
        total++; if (tries_left !== 2'd3) $display("FAIL reset_tries: got %0d expected 3", tries_left); else passed++;
        total++; if ({unlock, alarm, match_pulse, fail_pulse} !== 4'b0000)
            $display("FAIL reset_outputs: got %b expected 0000", {unlock, alarm, match_pulse, fail_pulse}); else passed++;
        total++; if (code_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", code_ready); else passed++;
    endtask

    task automatic test_unset_attempt();
        code_in = 16'd6969; code_valid = 1'b1; enroll = 1'b0;
        tick();
        code_valid = 1'b0;
        total++; if (state_o !== 3'd0) $display("FAIL unset_attempt_state: got %0d expected 0", state_o); else passed++;
        total++; if ({match_pulse, fail_pulse} !== 2'b00)
            $display("FAIL unset_attempt_pulse: got %b expected 00", {match_pulse, fail_pulse}); else passed++;
        tick();
        total++; if ({state_o, fail_pulse} !== 4'b0000)
            $display("FAIL unset_attempt_after: got %b expected 0000", {state_o, fail_pulse}); else passed++;
    endtask

    task automatic test_match();
        int cnt_unlock, cnt_match;
        enroll_code(16'd6969);
        total++; if (state_o !== 3'd1) $display("FAIL enroll_state: got %0d expected 1", state_o); else passed++;
        code_in = 16'd6969; code_valid = 1'b1; enroll = 1'b0;
        tick();
        code_valid = 1'b0;
        total++; if (state_o !== 3'd2) $display("FAIL check_state: got %0d expected 2", state_o); else passed++;
        total++; if ({code_ready, unlock} !== 2'b00)
            $display("FAIL check_ready_unlock: got %b expected 00", {code_ready, unlock}); else passed++;
        tick();
        total++; if ({state_o, unlock, match_pulse} !== 5'b011_1_1)
            $display("FAIL open_entry: got %b expected 01111", {state_o, unlock, match_pulse}); else passed++;
        cnt_unlock = 0; cnt_match = 0;
        for (int i = 0; i < 12; i++) begin
            if (unlock) cnt_unlock++;
            if (match_pulse) cnt_match++;
            tick();
        end
        total++; if (cnt_unlock != 8) $display("FAIL open_length: got %0d cycles expected 8", cnt_unlock); else passed++;
        total++; if (cnt_match != 1) $display("FAIL match_count: got %0d expected 1", cnt_match); else passed++;
        total++; if (state_o !== 3'd1) $display("FAIL open_expiry_state: got %0d expected 1", state_o); else passed++;
    endtask

    task automatic test_wrong_attempts();
        do_reset();
        enroll_code(16'd6969);
        attempt(16'd1234);
        total++; if ({fail_pulse, match_pulse, unlock} !== 3'b100)
            $display("FAIL wrong1_pulses: got %b expected 100", {fail_pulse, match_pulse, unlock}); else passed++;
        total++; if ({state_o, tries_left} !== 5'b001_10)
            $display("FAIL wrong1_state_tries: got %b expected 00110", {state_o, tries_left}); else passed++;
        tick();
        total++; if (fail_pulse !== 1'b0) $display("FAIL wrong1_pulse_width: got %b expected 0", fail_pulse); else passed++;
        attempt(16'd1234);
        total++; if ({fail_pulse, unlock, state_o, tries_left} !== 7'b1_0_001_01)
            $display("FAIL wrong2: got %b expected 1000101", {fail_pulse, unlock, state_o, tries_left}); else passed++;
    endtask

    task automatic test_lockout();
        int cnt_alarm, cnt_unlock;
        do_reset();
        enroll_code(16'd6969);
        repeat (3) attempt(16'd1234);
        total++; if ({alarm, fail_pulse, state_o, tries_left} !== 7'b1_1_100_00)
            $display("FAIL lockout_entry: got %b expected 1110000", {alarm, fail_pulse, state_o, tries_left}); else passed++;
        total++; if (code_ready !== 1'b0) $display("FAIL lockout_ready: got %b expected 0", code_ready); else passed++;
        cnt_alarm = 0; cnt_unlock = 0;
        for (int i = 0; i < 20; i++) begin
            if (alarm) cnt_alarm++;
            if (unlock) cnt_unlock++;
            code_in = 16'd6969; enroll = 1'b0; code_valid = (i < 10);
            tick();
        end
        code_valid = 1'b0;
        total++; if (cnt_alarm != 16) $display("FAIL lockout_length: got %0d cycles expected 16", cnt_alarm); else passed++;
        total++; if (cnt_unlock != 0) $display("FAIL lockout_ignored: got %0d unlock cycles expected 0", cnt_unlock); else passed++;
        total++; if ({state_o, alarm, tries_left} !== 6'b001_0_11)
            $display("FAIL lockout_exit: got %b expected 001011", {state_o, alarm, tries_left}); else passed++;
        attempt(16'd6969);
        total++; if (unlock !== 1'b1) $display("FAIL post_lockout_open: got %b expected 1", unlock); else passed++;
        repeat (10) tick();
    endtask

    task automatic test_relock();
        do_reset();
        enroll_code(16'd6969);
        attempt(16'd6969);
        repeat (3) tick();
        total++; if (unlock !== 1'b1) $display("FAIL relock_before: got %b expected 1", unlock); else passed++;
        relock = 1'b1;
        tick();
        relock = 1'b0;
        total++; if ({unlock, state_o} !== 4'b0_001)
            $display("FAIL relock_after: got %b expected 0001", {unlock, state_o}); else passed++;
        tick();
        total++; if ({unlock, state_o} !== 4'b0_001)
            $display("FAIL relock_hold: got %b expected 0001", {unlock, state_o}); else passed++;
    endtask

    task automatic test_enroll_in_open();
        attempt(16'd6969);
        code_in = 16'd4242; code_valid = 1'b1; enroll = 1'b1;
        tick();
        code_valid = 1'b0; enroll = 1'b0;
        total++; if ({unlock, state_o} !== 4'b0_001)
            $display("FAIL reenroll_state: got %b expected 0001", {unlock, state_o}); else passed++;
        attempt(16'd6969);
        total++; if ({fail_pulse, unlock, tries_left} !== 4'b1_0_10)
            $display("FAIL old_code_rejected: got %b expected 1010", {fail_pulse, unlock, tries_left}); else passed++;
        attempt(16'd4242);
        total++; if ({unlock, match_pulse, tries_left} !== 4'b1_1_11)
            $display("FAIL new_code_opens: got %b expected 1111", {unlock, match_pulse, tries_left}); else passed++;
        repeat (10) tick();
    endtask

    task automatic test_enroll_in_locked();
        code_in = 16'd1111; code_valid = 1'b1; enroll = 1'b1;
        tick();
        code_valid = 1'b0; enroll = 1'b0;
        total++; if ({fail_pulse, state_o, tries_left} !== 6'b1_001_11)
            $display("FAIL locked_enroll_reject: got %b expected 100111", {fail_pulse, state_o, tries_left}); else passed++;
        attempt(16'd4242);
        total++; if (unlock !== 1'b1) $display("FAIL locked_enroll_kept_code: got %b expected 1", unlock); else passed++;
        repeat (10) tick();
    endtask

    task automatic test_reset_mid_op();
        attempt(16'd4242);
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        total++; if ({unlock, state_o} !== 4'b0_000)
            $display("FAIL reset_mid_open: got %b expected 0000", {unlock, state_o}); else passed++;
        tick();
        reset_n = 1'b1;
        attempt(16'd4242);
        total++; if ({unlock, state_o} !== 4'b0_000)
            $display("FAIL erased_code: got %b expected 0000", {unlock, state_o}); else passed++;
        attempt(16'd6969);
        total++; if ({unlock, state_o} !== 4'b0_000)
            $display("FAIL unenrolled_6969: got %b expected 0000", {unlock, state_o}); else passed++;
        enroll_code(16'd6969);
        attempt(16'd6969);
        total++; if (unlock !== 1'b1) $display("FAIL reenrolled_open: got %b expected 1", unlock); else passed++;
        repeat (10) tick();
        repeat (3) attempt(16'd1234);
        total++; if (alarm !== 1'b1) $display("FAIL relockout_alarm: got %b expected 1", alarm); else passed++;
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        total++; if ({alarm, state_o, tries_left} !== 6'b0_000_11)
            $display("FAIL reset_mid_lockout: got %b expected 000011", {alarm, state_o, tries_left}); else passed++;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_unset_attempt();
        test_match();
        test_wrong_attempts();
        test_lockout();
        test_relock();
        test_enroll_in_open();
        test_enroll_in_locked();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
